// File: rtl/vec_int_div_pkg.sv
// Shared types for the vector integer divider: operand vector/scalar types,
// op and state encodings, and lane packing helpers.
package vec_int_div_pkg;

  localparam int DEF_LANES = 4;
  localparam int DEF_WIDTH = 32;

  typedef logic [DEF_WIDTH-1:0]           scalar_t;
  typedef logic [DEF_LANES*DEF_WIDTH-1:0] vector_t;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } state_e;

  // Lane i occupies bits [lane_lsb(i, width) +: width] of a packed vector.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return ~o[0];
  endfunction

  function automatic logic op_is_rem(input op_e o);
    return o[1];
  endfunction

endpackage

// File: rtl/vec_div_lane.sv
// One divider lane: operand magnitude capture, radix-2 restoring step and
// final sign/zero-divisor correction of quotient or remainder.
module vec_div_lane
  import vec_int_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_signed,
  input  logic             i_rem,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_res
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] r_d;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;

  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  // r_q starts as |dividend| and shifts quotient bits in as dividend bits leave.
  assign w_trial = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_ge    = (w_trial >= {1'b0, r_d});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else if (i_load) begin
      r_q     <= (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
      r_d     <= (i_signed && i_d[WIDTH-1]) ? -i_d : i_d;
      r_r     <= '0;
      r_neg_q <= i_signed && (i_a[WIDTH-1] ^ i_d[WIDTH-1]);
      r_neg_r <= i_signed && i_a[WIDTH-1];
      r_dz    <= (i_d == '0);
    end else if (i_step) begin
      r_r <= w_ge ? (w_trial - {1'b0, r_d}) : w_trial;
      r_q <= {r_q[WIDTH-2:0], w_ge};
    end
  end

  // A zero divisor leaves the full dividend in r_r, so only the quotient needs forcing.
  assign w_quo = r_dz ? '1 : (r_neg_q ? -r_q : r_q);
  assign w_rem = WIDTH'(r_neg_r ? -r_r : r_r);
  assign o_res = i_rem ? w_rem : w_quo;

endmodule

// File: rtl/vec_int_div.sv
// Multi-lane iterative integer divider (DIV/DIVU/REM/REMU) with one shared FSM.
// Define VEC_DIV_ZERO_FLAG_EN to add the per-lane dz_mask output.
module vec_int_div
  import vec_int_div_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             op,
  input  logic                   use_imm,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  input  logic [WIDTH-1:0]       imm,
  input  logic                   stall,
  output logic                   busy,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] out
`ifdef VEC_DIV_ZERO_FLAG_EN
  ,
  output logic [LANES-1:0]       dz_mask
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e                 r_state;
  logic [CW-1:0]          r_cnt;
  op_e                    r_op;
  logic [LANES*WIDTH-1:0] r_a;
  logic [LANES*WIDTH-1:0] r_b;
  logic [LANES*WIDTH-1:0] r_out;
  logic                   r_busy;
  logic                   r_out_valid;
`ifdef VEC_DIV_ZERO_FLAG_EN
  logic [LANES-1:0]       r_dz_mask;
`endif

  logic                   w_load;
  logic                   w_step;
  logic [LANES*WIDTH-1:0] w_res;

  // ITER holds one extra cycle at terminal count; only WIDTH of its cycles step.
  assign w_load = (r_state == ST_PREP);
  assign w_step = (r_state == ST_ITER) && (r_cnt != CW'(WIDTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_op        <= OP_DIV;
      r_a         <= '0;
      r_b         <= '0;
      r_out       <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef VEC_DIV_ZERO_FLAG_EN
      r_dz_mask   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op    <= op_e'(op);
            r_a     <= a;
            r_b     <= use_imm ? {LANES{imm}} : b;
            r_busy  <= 1'b1;
            r_state <= ST_PREP;
          end
        end
        ST_PREP: begin
          r_cnt   <= '0;
          r_state <= ST_ITER;
        end
        ST_ITER: begin
          if (r_cnt == CW'(WIDTH)) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_FIX: begin
          r_out       <= w_res;
          r_out_valid <= 1'b1;
`ifdef VEC_DIV_ZERO_FLAG_EN
          for (int i = 0; i < LANES; i++) begin
            r_dz_mask[i] <= (r_b[lane_lsb(i, WIDTH) +: WIDTH] == '0);
          end
`endif
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (!stall) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    vec_div_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_step  (w_step),
      .i_signed(op_is_signed(r_op)),
      .i_rem   (op_is_rem(r_op)),
      .i_a     (r_a[lane_lsb(gi, WIDTH) +: WIDTH]),
      .i_d     (r_b[lane_lsb(gi, WIDTH) +: WIDTH]),
      .o_res   (w_res[lane_lsb(gi, WIDTH) +: WIDTH])
    );
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out       = r_out;
`ifdef VEC_DIV_ZERO_FLAG_EN
  assign dz_mask   = r_dz_mask;
`endif

endmodule

// File: tb/tb_vec_int_div.sv
// Scoreboard bench for vec_int_div: directed vectors with hand-computed results,
// latency, stall hold, ignored start, zero divisor, overflow and mid-op reset.
module tb_vec_int_div;
  import vec_int_div_pkg::*;

  localparam int LANES = 4;
  localparam int WIDTH = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic       use_imm = 1'b0;
  logic       stall = 1'b0;
  vector_t    a = '0;
  vector_t    b = '0;
  scalar_t    imm = '0;
  logic       busy;
  logic       out_valid;
  vector_t    out;
`ifdef VEC_DIV_ZERO_FLAG_EN
  logic [LANES-1:0] dz_mask;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    vector_t    val;
    logic [3:0] dz;
    string      tag;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  vec_int_div #(
    .LANES(LANES),
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .use_imm  (use_imm),
    .a        (a),
    .b        (b),
    .imm      (imm),
    .stall    (stall),
    .busy     (busy),
    .out_valid(out_valid),
    .out      (out)
`ifdef VEC_DIV_ZERO_FLAG_EN
    ,
    .dz_mask  (dz_mask)
`endif
  );

  function automatic vector_t pack4(input scalar_t l0, input scalar_t l1,
                                    input scalar_t l2, input scalar_t l3);
    vector_t v;
    v[lane_lsb(0, WIDTH) +: WIDTH] = l0;
    v[lane_lsb(1, WIDTH) +: WIDTH] = l1;
    v[lane_lsb(2, WIDTH) +: WIDTH] = l2;
    v[lane_lsb(3, WIDTH) +: WIDTH] = l3;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted result (valid and not stalled) is matched against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && out_valid && !stall) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got %h, expected no result", out);
        end else begin
          e = sb.pop_front();
          $display("result %s out=%h", e.tag, out);
          check({e.tag, " out"}, out, e.val);
`ifdef VEC_DIV_ZERO_FLAG_EN
          check({e.tag, " dz_mask"}, 128'(dz_mask), 128'(e.dz));
`endif
        end
      end
    end
  end

  task automatic run(input string tag, input logic [1:0] op_i, input logic ui,
                     input vector_t a_i, input vector_t b_i, input scalar_t imm_i,
                     input vector_t exp_v, input logic [3:0] exp_dz,
                     input int stall_cyc, input bit pulse);
    int   k;
    exp_t e;
    @(posedge clk); #1;
    e.val = exp_v;
    e.dz  = exp_dz;
    e.tag = tag;
    sb.push_back(e);
    op = op_i; use_imm = ui; a = a_i; b = b_i; imm = imm_i; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~a_i;
    b = '0;
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
      if (pulse && k == 10) begin
        start = 1'b1;
        a = '0;
      end
      if (pulse && k == 11) start = 1'b0;
    end
    check({tag, " latency"}, 128'(k), 128'(35));
    if (stall_cyc > 0) begin
      stall = 1'b1;
      for (int i = 0; i < stall_cyc; i++) begin
        @(posedge clk); #1;
        check({tag, " stall out"}, out, exp_v);
        check({tag, " stall valid"}, 128'(out_valid), 128'(1));
        check({tag, " stall busy"}, 128'(busy), 128'(1));
      end
      stall = 1'b0;
    end
    k = 0;
    while (busy && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, " idle"}, 128'(busy), 128'(0));
    if (pulse) begin
      repeat (40) @(posedge clk);
      #1;
      check({tag, " ignored start"}, 128'({busy, out_valid}), 128'(0));
    end
  endtask

  initial begin
    int      k;
    vector_t va, vb;

    #2;
    check("reset busy", 128'(busy), 128'(0));
    check("reset valid", 128'(out_valid), 128'(0));
    check("reset out", out, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    va = pack4(32'd100, 32'd20, scalar_t'(-9), 32'd7);
    vb = pack4(32'd7, scalar_t'(-3), 32'd2, 32'd8);
    run("div_basic", 2'b00, 1'b0, va, vb, '0,
        pack4(32'd14, scalar_t'(-6), scalar_t'(-4), 32'd0), 4'b0000, 0, 1'b0);

    va = pack4(scalar_t'(-100), 32'd20, scalar_t'(-9), 32'd7);
    run("rem_signed", 2'b10, 1'b0, va, vb, '0,
        pack4(scalar_t'(-2), 32'd2, scalar_t'(-1), 32'd7), 4'b0000, 0, 1'b0);
    run("div_signed", 2'b00, 1'b0, va, vb, '0,
        pack4(scalar_t'(-14), scalar_t'(-6), scalar_t'(-4), 32'd0), 4'b0000, 0, 1'b0);

    run("remu", 2'b11, 1'b0,
        pack4(32'hFFFFFFFF, 32'd100, 32'h80000000, 32'hFFFFFF9C),
        pack4(32'd16, 32'd7, 32'd3, 32'd7), '0,
        pack4(32'd15, 32'd2, 32'd2, 32'd2), 4'b0000, 0, 1'b0);

    run("divu_dz", 2'b01, 1'b0,
        pack4(32'd1000, 32'hFFFFFFFF, 32'd55, 32'hFFFFFF9C),
        pack4(32'd10, 32'd2, 32'd0, 32'd7), '0,
        pack4(32'd100, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd613566742), 4'b0100, 0, 1'b0);

    run("rem_dz", 2'b10, 1'b0,
        pack4(scalar_t'(-7), scalar_t'(-5), 32'd55, 32'd0),
        pack4(32'd2, 32'd0, 32'd0, 32'd5), '0,
        pack4(scalar_t'(-1), scalar_t'(-5), 32'd55, 32'd0), 4'b0110, 0, 1'b0);

    va = pack4(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd100);
    vb = pack4(32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF);
    run("div_ovf", 2'b00, 1'b0, va, vb, '0,
        pack4(32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, scalar_t'(-100)), 4'b0110, 0, 1'b0);
    run("rem_ovf", 2'b10, 1'b0, va, vb, '0,
        pack4(32'd0, 32'hFFFFFFFF, 32'h80000000, 32'd0), 4'b0110, 0, 1'b0);

    run("imm_stall", 2'b00, 1'b1, pack4(32'd9, 32'd10, 32'd11, 32'd12),
        pack4(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'd3,
        pack4(32'd3, 32'd3, 32'd3, 32'd4), 4'b0000, 5, 1'b1);

    // Abort an operation mid-ITER; no result may appear for it.
    @(posedge clk); #1;
    op = 2'b00; use_imm = 1'b0;
    a = pack4(32'd50, 32'd60, 32'd70, 32'd80);
    b = pack4(32'd5, 32'd6, 32'd7, 32'd8);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort busy", 128'(busy), 128'(0));
    check("abort valid", 128'(out_valid), 128'(0));
    check("abort out", out, '0);
    @(posedge clk); #1;
    rst = 1'b1;

    run("after_reset", 2'b00, 1'b0,
        pack4(32'd100, 32'd20, scalar_t'(-9), 32'd7),
        pack4(32'd7, scalar_t'(-3), 32'd2, 32'd8), '0,
        pack4(32'd14, scalar_t'(-6), scalar_t'(-4), 32'd0), 4'b0000, 0, 1'b0);

    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    check("scoreboard drained", 128'(sb.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vec_int_div.md
VEC_INT_DIV -- requirements
Module: vec_int_div

Interface
REQ-001 SHALL have parameter LANES, default 4: number of independent vector lanes.
REQ-002 SHALL have parameter WIDTH, default 32: bits per lane operand and result.
REQ-003 SHALL have port clk  input  1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1: request; sampled only in IDLE.
REQ-006 SHALL have port op  input  2: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
REQ-007 SHALL have port use_imm  input  1: when 1, imm replaces every lane divisor.
REQ-008 SHALL have port a  input  LANES*WIDTH: dividend vector, lane i at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port b  input  LANES*WIDTH: divisor vector, same packing as a.
REQ-010 SHALL have port imm  input  WIDTH: broadcast divisor.
REQ-011 SHALL have port stall  input  1: downstream not ready; holds a completed result.
REQ-012 SHALL have port busy  output  1: high in every state except IDLE.
REQ-013 SHALL have port out_valid  output  1: result on out is valid.
REQ-014 SHALL have port out  output  LANES*WIDTH: result vector, same packing as a.

Function
REQ-015 SHALL implement one shared FSM: IDLE, PREP, ITER, FIX, DONE.
REQ-016 SHALL move IDLE->PREP on start=1, registering op, a, and the effective divisor; start in any other state SHALL be ignored.
REQ-017 In PREP, SHALL take absolute values of operands for signed ops and record per-lane quotient and remainder signs.
REQ-018 In ITER, SHALL perform one radix-2 restoring step per lane per cycle for exactly WIDTH cycles, counted by a log2(WIDTH)+1-bit counter; then go to FIX.
REQ-019 In FIX, SHALL apply signs (quotient negative iff signs differ; remainder takes dividend sign), select quotient or remainder per op, register out, and go to DONE.
REQ-020 out_valid SHALL be high only in DONE; with start sampled at edge N, out_valid SHALL rise after edge N+WIDTH+3.
REQ-021 In DONE with stall=1, SHALL remain in DONE with out stable; with stall=0, SHALL go to IDLE at the next edge.
REQ-022 stall SHALL have no effect in PREP, ITER or FIX.
REQ-023 Divisor zero in a lane: quotient SHALL be all-ones and remainder SHALL equal the dividend, signed and unsigned alike.
REQ-024 Signed overflow (dividend = most negative value, divisor = -1): quotient SHALL be the most negative value and remainder SHALL be 0.
REQ-025 Lanes SHALL be fully independent; a special case in one lane SHALL not alter other lanes.
REQ-026 Arithmetic SHALL be WIDTH bits modulo 2^WIDTH; the partial remainder register SHALL be WIDTH+1 bits.

Reset
REQ-027 On rst low, SHALL enter IDLE asynchronously, with busy=0, out_valid=0, out=0 and the counter at 0.
REQ-028 Reset mid-operation SHALL abort it with no result produced; operation resumes only on a new start after rst rises.

Configuration
REQ-029 With VEC_DIV_ZERO_FLAG_EN defined, SHALL add output dz_mask (LANES bits), registered in FIX, bit i = lane i divisor was zero, valid with out_valid, reset 0.
REQ-030 Without VEC_DIV_ZERO_FLAG_EN, dz_mask SHALL be absent and all other behaviour identical.

Structure
REQ-031 The op encoding enum, state enum, and lane packing helpers SHALL live in the shared package alongside the existing vector and scalar types.
REQ-032 The per-lane datapath (abs, step, sign fix) SHALL be sub-module vec_div_lane, instantiated LANES times by generate; the FSM and counter stay in vec_int_div.

Verification
All scenarios use WIDTH=32, LANES=4.
REQ-033 DIV, a lane0=100, b lane0=7 -> out lane0=14, out_valid after exactly 35 cycles.
REQ-034 REM, a=-100, b=7 -> -2; DIV, a=-100, b=7 -> -14; REMU, a=0xFFFFFFFF, b=16 -> 15.
REQ-035 DIVU with b lane2=0, a lane2=55 -> lane2=0xFFFFFFFF, other lanes correct, dz_mask=0100 when enabled; REM with b=0, a=55 -> 55.
REQ-036 DIV, a=0x80000000, b=0xFFFFFFFF -> quotient 0x80000000; REM with the same operands -> 0.
REQ-037 use_imm=1, imm=3, a={9,10,11,12} -> {3,3,3,4}; stall held 5 cycles in DONE -> out stable, busy=1, and a start pulse during ITER is ignored.
REQ-038 rst low during ITER -> busy=0, out_valid=0, out=0 immediately; a new start after release completes normally.
